// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with same-cycle write bypass, optional
// hard-wired zero register and a one-register-per-cycle clear sweep.
module regfile_2r1w #(
   parameter int WIDTH   = 16,
   parameter int REGS    = 16,
   parameter int ADDR_W  = $clog2(REGS),
   parameter bit R0_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [WIDTH-1:0]  wrData,
   input  logic [ADDR_W-1:0] rdAddrA,
   input  logic [ADDR_W-1:0] rdAddrB,
   output logic [WIDTH-1:0]  rdDataA,
   output logic [WIDTH-1:0]  rdDataB,
   input  logic              clear,
   output logic              busy,
   output logic              done,
   output logic              wrReject
);

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] ptr_reg;
   logic              done_reg;
   logic [WIDTH-1:0]  regs_reg [REGS];

   logic              wr_drop;
   logic              wr_ok;
   logic              sweeping;
   logic [REGS-1:0]   wr_sel;
   logic [REGS-1:0]   clr_sel;

   assign sweeping = (state_reg == SWEEP);
   assign wr_drop  = R0_ZERO && (wrAddr == '0);
   assign wr_ok    = wrEn && !sweeping && !wr_drop;
   assign wrReject = wrEn && (sweeping || wr_drop);
   assign busy     = sweeping;
   assign done     = done_reg;

   // Per-register decode: the sweep owns the file, so a write is never
   // selected while clr_sel can be active.
   generate
      for (genvar gi = 0; gi < REGS; gi++) begin : g_sel
         assign wr_sel[gi]  = wr_ok && (wrAddr == ADDR_W'(gi));
         assign clr_sel[gi] = sweeping && (ptr_reg == ADDR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REGS; i++) regs_reg[i] <= '0;
      end else begin
         for (int i = 0; i < REGS; i++) begin
            if (clr_sel[i])
               regs_reg[i] <= '0;
            else if (wr_sel[i])
               regs_reg[i] <= wrData;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (clear) begin
                  state_reg <= SWEEP;
                  ptr_reg   <= '0;
               end
            end
            SWEEP: begin
               if (ptr_reg == ADDR_W'(REGS - 1)) begin
                  state_reg <= IDLE;
                  ptr_reg   <= '0;
                  done_reg  <= 1'b1;
               end else begin
                  ptr_reg <= ptr_reg + ADDR_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Zero register overrides bypass, bypass overrides stored contents.
   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [WIDTH-1:0] val;
      val = regs_reg[addr];
      if (wr_ok && (wrAddr == addr)) val = wrData;
      if (R0_ZERO && (addr == '0)) val = '0;
      return val;
   endfunction

   assign rdDataA = read_port(rdAddrA);
   assign rdDataB = read_port(rdAddrB);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: 16x16 with and without zero register sharing one
// stimulus stream against an array model, plus a 32x32 instance.
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic [3:0]  rd_a = '0;
   logic [3:0]  rd_b = '0;
   logic        clr = 1'b0;
   logic [15:0] a0, b0, a1, b1;
   logic        busy0, done0, rej0, busy1, done1, rej1;

   logic        we2 = 1'b0;
   logic [4:0]  wa2 = '0;
   logic [31:0] wd2 = '0;
   logic [4:0]  ra2 = '0;
   logic [4:0]  rb2 = '0;
   logic        clr2 = 1'b0;
   logic [31:0] a2, b2;
   logic        busy2, done2, rej2;

   int n_vec = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   regfile_2r1w #(.WIDTH(16), .REGS(16), .R0_ZERO(1'b0)) dut0 (
      .clk(clk), .reset(rst_n), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
      .rdAddrA(rd_a), .rdAddrB(rd_b), .rdDataA(a0), .rdDataB(b0),
      .clear(clr), .busy(busy0), .done(done0), .wrReject(rej0));

   regfile_2r1w #(.WIDTH(16), .REGS(16), .R0_ZERO(1'b1)) dut1 (
      .clk(clk), .reset(rst_n), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
      .rdAddrA(rd_a), .rdAddrB(rd_b), .rdDataA(a1), .rdDataB(b1),
      .clear(clr), .busy(busy1), .done(done1), .wrReject(rej1));

   regfile_2r1w #(.WIDTH(32), .REGS(32)) dut2 (
      .clk(clk), .reset(rst_n), .wrEn(we2), .wrAddr(wa2), .wrData(wd2),
      .rdAddrA(ra2), .rdAddrB(rb2), .rdDataA(a2), .rdDataB(b2),
      .clear(clr2), .busy(busy2), .done(done2), .wrReject(rej2));

   // Reference model: contents of both 16-entry files, sweep progress, done.
   logic [15:0] m [2][16];
   bit          swp;
   int          swp_idx;
   bit          m_done;

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) m[d][i] = '0;
      swp = 0;
      swp_idx = 0;
      m_done = 0;
   endtask

   // Apply the effect of the coming rising edge using the current inputs.
   task automatic model_step();
      bit nd;
      nd = 0;
      if (!swp) begin
         if (wr_en)
            for (int d = 0; d < 2; d++)
               if (!(d == 1 && wr_addr == 0)) m[d][wr_addr] = wr_data;
         if (clr) begin
            swp = 1;
            swp_idx = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) m[d][swp_idx] = '0;
         swp_idx++;
         if (swp_idx == 16) begin
            swp = 0;
            nd = 1;
         end
      end
      m_done = nd;
   endtask

   function automatic logic [15:0] exp_rd(int d, logic [3:0] addr);
      if (d == 1 && addr == 0) return '0;
      if (!swp && wr_en && wr_addr == addr && !(d == 1 && wr_addr == 0)) return wr_data;
      return m[d][addr];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(string tag);
      for (int d = 0; d < 2; d++) begin
         logic rj;
         rj = wr_en && (swp || (d == 1 && wr_addr == 0));
         chk($sformatf("%s rdA%0d", tag, d), (d == 1) ? 32'(a1) : 32'(a0), 32'(exp_rd(d, rd_a)));
         chk($sformatf("%s rdB%0d", tag, d), (d == 1) ? 32'(b1) : 32'(b0), 32'(exp_rd(d, rd_b)));
         chk($sformatf("%s rej%0d", tag, d), (d == 1) ? 32'(rej1) : 32'(rej0), 32'(rj));
         chk($sformatf("%s busy%0d", tag, d), (d == 1) ? 32'(busy1) : 32'(busy0), 32'(swp));
         chk($sformatf("%s done%0d", tag, d), (d == 1) ? 32'(done1) : 32'(done0), 32'(m_done));
      end
      $display("%s: we=%0d wa=%0d wd=%h ra=%0d rb=%0d clr=%0d -> a0=%h b0=%h a1=%h b1=%h busy=%0d done=%0d",
               tag, wr_en, wr_addr, wr_data, rd_a, rd_b, clr, a0, b0, a1, b1, busy0, done0);
   endtask

   task automatic set_in(logic we, logic [3:0] wa, logic [15:0] wd,
                         logic [3:0] ra, logic [3:0] rb, logic c);
      wr_en = we; wr_addr = wa; wr_data = wd; rd_a = ra; rd_b = rb; clr = c;
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [15:0] ea0;
      logic [15:0] eb0;
      logic        ej0;
      logic [15:0] ea1;
      logic [15:0] eb1;
      logic        ej1;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int busy_cnt;
      int done_cnt;

      tbl[0] = '{1'b1, 4'd1, 16'd5,      4'd1, 4'd2, 16'd5,      16'd0,      1'b0, 16'd5,  16'd0,  1'b0};
      tbl[1] = '{1'b1, 4'd2, 16'd4,      4'd1, 4'd2, 16'd5,      16'd4,      1'b0, 16'd5,  16'd4,  1'b0};
      tbl[2] = '{1'b1, 4'd3, 16'd2,      4'd3, 4'd2, 16'd2,      16'd4,      1'b0, 16'd2,  16'd4,  1'b0};
      tbl[3] = '{1'b0, 4'd0, 16'd0,      4'd1, 4'd2, 16'd5,      16'd4,      1'b0, 16'd5,  16'd4,  1'b0};
      tbl[4] = '{1'b0, 4'd0, 16'd0,      4'd3, 4'd3, 16'd2,      16'd2,      1'b0, 16'd2,  16'd2,  1'b0};
      tbl[5] = '{1'b1, 4'd7, 16'hBEEF,   4'd7, 4'd7, 16'hBEEF,   16'hBEEF,   1'b0, 16'hBEEF, 16'hBEEF, 1'b0};
      tbl[6] = '{1'b0, 4'd0, 16'd0,      4'd7, 4'd7, 16'hBEEF,   16'hBEEF,   1'b0, 16'hBEEF, 16'hBEEF, 1'b0};
      tbl[7] = '{1'b1, 4'd0, 16'h1234,   4'd0, 4'd0, 16'h1234,   16'h1234,   1'b0, 16'd0,  16'd0,  1'b1};
      tbl[8] = '{1'b0, 4'd0, 16'd0,      4'd0, 4'd0, 16'h1234,   16'h1234,   1'b0, 16'd0,  16'd0,  1'b0};

      // Reset state
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table
      for (int i = 0; i < 9; i++) begin
         set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, 1'b0);
         #1;
         chk($sformatf("tbl%0d a0", i), 32'(a0), 32'(tbl[i].ea0));
         chk($sformatf("tbl%0d b0", i), 32'(b0), 32'(tbl[i].eb0));
         chk($sformatf("tbl%0d rej0", i), 32'(rej0), 32'(tbl[i].ej0));
         chk($sformatf("tbl%0d a1", i), 32'(a1), 32'(tbl[i].ea1));
         chk($sformatf("tbl%0d b1", i), 32'(b1), 32'(tbl[i].eb1));
         chk($sformatf("tbl%0d rej1", i), 32'(rej1), 32'(tbl[i].ej1));
         $display("tbl%0d: we=%0d wa=%0d wd=%h ra=%0d rb=%0d -> a0=%h b0=%h a1=%h b1=%h",
                  i, wr_en, wr_addr, wr_data, rd_a, rd_b, a0, b0, a1, b1);
         tick();
      end

      // Fill with i+1, then a full sweep
      for (int i = 0; i < 16; i++) begin
         set_in(1'b1, 4'(i), 16'(i + 1), 4'(i), 4'((i + 1) % 16), 1'b0);
         #1; check_all("fill");
         tick();
      end
      set_in(1'b0, 4'd0, 16'd0, 4'd4, 4'd5, 1'b1);
      #1; check_all("clear");
      tick();
      clr = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         if (!busy0) break;
         set_in(n == 3, 4'd5, 16'hAAAA, (n == 2) ? 4'd1 : 4'(n), (n == 2) ? 4'd2 : 4'(15 - n), 1'b0);
         #1;
         check_all("sweep");
         if (n == 2) begin
            chk("sweep r1 zero", 32'(a0), 32'd0);
            chk("sweep r2 kept", 32'(b0), 32'd3);
         end
         if (n == 3) chk("sweep reject", 32'(rej0), 32'd1);
         if (done0) done_cnt++;
         busy_cnt++;
         tick();
      end
      chk("busy cycles", 32'(busy_cnt), 32'd16);
      set_in(1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0);
      #1; check_all("after sweep");
      if (done0) done_cnt++;
      tick();
      #1; check_all("after sweep2");
      if (done0) done_cnt++;
      chk("done pulses", 32'(done_cnt), 32'd1);
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 4'd0, 16'd0, 4'(i), 4'(i + 8), 1'b0);
         #1; check_all("zeroed");
         chk("zeroed a", 32'(a0), 32'd0);
         chk("zeroed b", 32'(b0), 32'd0);
         tick();
      end

      // Reset asserted in the 8th cycle of a sweep
      for (int i = 0; i < 16; i++) begin
         set_in(1'b1, 4'(i), 16'(16'h100 + i), 4'(i), 4'd15, 1'b0);
         #1; check_all("refill");
         tick();
      end
      set_in(1'b0, 4'd0, 16'd0, 4'd9, 4'd15, 1'b1);
      #1; check_all("clear2");
      tick();
      clr = 1'b0;
      for (int n = 0; n < 7; n++) begin
         #1; check_all("sweep2");
         tick();
      end
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 4'd0, 16'd0, 4'(i), 4'(i + 8), 1'b0);
         #1; check_all("rst mid");
         chk("rst mid b", 32'(b0), 32'd0);
      end
      chk("rst mid busy", 32'(busy0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 20; n++) begin
         set_in(1'b0, 4'd0, 16'd0, 4'(n), 4'(15 - n), 1'b0);
         #1; check_all("post rst");
         chk("post rst done", 32'(done0), 32'd0);
         tick();
      end

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [3:0] wa;
         wa = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         set_in(1'($urandom_range(0, 1)), wa, 16'($urandom),
                ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 24) == 0) || (swp && $urandom_range(0, 3) == 0));
         #1; check_all("rand");
         tick();
      end
      set_in(1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0);

      // 32 x 32 instance
      we2 = 1'b1; wa2 = 5'd31; wd2 = 32'hDEADBEEF; ra2 = 5'd31; rb2 = 5'd0;
      #1;
      chk("w32 bypass", a2, 32'hDEADBEEF);
      tick();
      we2 = 1'b0;
      #1;
      chk("w32 stored", a2, 32'hDEADBEEF);
      $display("w32: r31=%h", a2);
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      busy_cnt = 0;
      for (int n = 0; n < 80; n++) begin
         if (!busy2) break;
         busy_cnt++;
         tick();
      end
      chk("w32 busy cycles", 32'(busy_cnt), 32'd32);
      chk("w32 done", 32'(done2), 32'd1);
      chk("w32 r31 zero", a2, 32'd0);
      $display("w32: busy=%0d cycles r31=%h done=%0d", busy_cnt, a2, done2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
